lcd_bus_sched: RTL

Owns the shared character LCD (HD44780-style, 2x16) for the calculator. Two requesters (calculator core, status/debug) write characters into a 32-entry display buffer through a round-robin arbitrated write port. A tick-paced FSM runs power-up initialisation, then continuously refreshes both lines from the buffer. It also services a clear request at frame boundaries.

---
 rtl/lcd_bus_sched.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_bus_sched.sv
// lcd_bus_sched: owns a 2x16 HD44780-style character LCD.
// Two requesters write into a 32-entry character buffer through a
// round-robin write port. A tick-paced FSM initialises the panel and
// then keeps refreshing both lines from the buffer. A clear request
// blanks the buffer and schedules a panel clear at the next frame end.
module lcd_bus_sched #(
    parameter int CLK_DIV   = 5,
    parameter int INIT_WAIT = 70,
    parameter int CLR_WAIT  = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [4:0] req0_addr,
    input  logic [7:0] req0_char,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [4:0] req1_addr,
    input  logic [7:0] req1_char,
    output logic       req1_ready,
    input  logic       clr_req,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data,
    output logic       init_done
);

    localparam int DIV_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int WAIT_MAX = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
    localparam int TW       = $clog2(WAIT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TW-1:0]    INIT_LAST = TW'(INIT_WAIT - 1);
    localparam logic [TW-1:0]    CLR_LAST  = TW'(CLR_WAIT - 1);

    localparam logic [7:0] BLANK = 8'h20;

    localparam logic [3:0] ST_PWR_WAIT = 4'd0;
    localparam logic [3:0] ST_FSET     = 4'd1;
    localparam logic [3:0] ST_DISP     = 4'd2;
    localparam logic [3:0] ST_ENTRY    = 4'd3;
    localparam logic [3:0] ST_CLEAR    = 4'd4;
    localparam logic [3:0] ST_CLR_IDLE = 4'd5;
    localparam logic [3:0] ST_L1_ADDR  = 4'd6;
    localparam logic [3:0] ST_L1_CHR   = 4'd7;
    localparam logic [3:0] ST_L2_ADDR  = 4'd8;
    localparam logic [3:0] ST_L2_CHR   = 4'd9;

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       state;
    logic             phase;        // 0 = phase A (E high), 1 = phase B (E low)
    logic [TW-1:0]    wait_cnt;
    logic [3:0]       col;
    logic             clr_pending;
    logic             rr_last;      // 0 = req0 won the last conflict, 1 = req1
    logic [7:0]       buf_mem [32];

    logic             gnt0;
    logic             gnt1;
    logic             xfer;
    logic             xfer_rs;
    logic [7:0]       xfer_data;
    logic [3:0]       xfer_next;

    assign tick       = (div_cnt == DIV_LAST);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign lcd_rw     = 1'b0;

    // Tick divider: one-clk pulse every CLK_DIV clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Write-port arbitration: clear blocks all grants, conflicts alternate.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst || clr_req) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end else if (req0_valid && req1_valid) begin
            if (rr_last) begin
                gnt0 = 1'b1;
            end else begin
                gnt1 = 1'b1;
            end
        end else if (req0_valid) begin
            gnt0 = 1'b1;
        end else if (req1_valid) begin
            gnt1 = 1'b1;
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Round-robin memory: only a granted conflict moves the pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (req0_valid && req1_valid && !clr_req) begin
            rr_last <= gnt1;
        end else begin
            rr_last <= rr_last;
        end
    end

    // Character buffer: blanked by clear, otherwise takes the granted write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) buf_mem[i] <= BLANK;
        end else if (clr_req) begin
            for (int i = 0; i < 32; i++) buf_mem[i] <= BLANK;
        end else if (gnt0) begin
            buf_mem[req0_addr] <= req0_char;
        end else if (gnt1) begin
            buf_mem[req1_addr] <= req1_char;
        end
    end

    // Per-state bus byte and successor for states that perform an LCD write.
    always_comb begin
        xfer      = 1'b1;
        xfer_rs   = 1'b0;
        xfer_data = 8'h00;
        xfer_next = state;
        case (state)
            ST_FSET:    begin xfer_data = 8'h38; xfer_next = ST_DISP;     end
            ST_DISP:    begin xfer_data = 8'h0C; xfer_next = ST_ENTRY;    end
            ST_ENTRY:   begin xfer_data = 8'h06; xfer_next = ST_CLEAR;    end
            ST_CLEAR:   begin xfer_data = 8'h01; xfer_next = ST_CLR_IDLE; end
            ST_L1_ADDR: begin xfer_data = 8'h80; xfer_next = ST_L1_CHR;   end
            ST_L2_ADDR: begin xfer_data = 8'hC0; xfer_next = ST_L2_CHR;   end
            ST_L1_CHR: begin
                xfer_rs   = 1'b1;
                xfer_data = buf_mem[{1'b0, col}];
                xfer_next = (col == 4'd15) ? ST_L2_ADDR : ST_L1_CHR;
            end
            ST_L2_CHR: begin
                xfer_rs   = 1'b1;
                xfer_data = buf_mem[{1'b1, col}];
                if (col == 4'd15) begin
                    xfer_next = clr_pending ? ST_CLEAR : ST_L1_ADDR;
                end else begin
                    xfer_next = ST_L2_CHR;
                end
            end
            default: begin
                xfer      = 1'b0;
                xfer_next = state;
            end
        endcase
    end

    // Sequencer: waits, two-tick bus writes, frame refresh and clear tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_PWR_WAIT;
            phase       <= 1'b0;
            wait_cnt    <= '0;
            col         <= 4'd0;
            clr_pending <= 1'b0;
            init_done   <= 1'b0;
            lcd_e       <= 1'b0;
            lcd_rs      <= 1'b0;
            lcd_data    <= 8'h00;
        end else begin
            if (tick) begin
                if (xfer) begin
                    if (!phase) begin
                        lcd_e    <= 1'b1;
                        lcd_rs   <= xfer_rs;
                        lcd_data <= xfer_data;
                        phase    <= 1'b1;
                    end else begin
                        lcd_e <= 1'b0;
                        phase <= 1'b0;
                        state <= xfer_next;
                        if (state == ST_L1_CHR || state == ST_L2_CHR) begin
                            col <= col + 4'd1;
                        end
                    end
                end else if (state == ST_PWR_WAIT) begin
                    lcd_e <= 1'b0;
                    if (wait_cnt == INIT_LAST) begin
                        wait_cnt <= '0;
                        state    <= ST_FSET;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end else if (state == ST_CLR_IDLE) begin
                    lcd_e <= 1'b0;
                    if (wait_cnt == CLR_LAST) begin
                        wait_cnt    <= '0;
                        state       <= ST_L1_ADDR;
                        init_done   <= 1'b1;
                        clr_pending <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end else begin
                    // Unreachable encoding: restart the power-up sequence.
                    lcd_e    <= 1'b0;
                    phase    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_PWR_WAIT;
                end
            end
            // A new clear request wins over the end-of-idle acknowledge.
            if (clr_req) begin
                clr_pending <= 1'b1;
            end
        end
    end

endmodule
